csa_pipe: RTL and testbench

CSA_PIPE -- requirements
Module: csa_pipe

---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_block.sv | 25 ++
 rtl/csa_pipe.sv | 138 +++++++++++++
 tb/tb_csa_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants and configuration checks for the pipelined
// carry-select adder/subtractor.
package csa_pkg;

  localparam int CSA_WIDTH  = 32;
  localparam int CSA_BLOCK  = 4;
  localparam int CSA_STAGES = 2;

  function automatic bit csa_params_ok(
    input int w,
    input int b,
    input int s
  );
    return (w > 0) && (b > 0) && (s >= 1) &&
           (w % b == 0) && ((w / b) % s == 0);
  endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select slice: both carry-in cases are added up front,
// and the real incoming carry only drives the final mux.
module csa_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             c_i,
  output logic [BLOCK-1:0] s_o,
  output logic             c_o,
  output logic             mc_o
);

  logic [BLOCK:0] r0;
  logic [BLOCK:0] r1;

  assign r0 = {1'b0, a_i} + {1'b0, b_i};
  assign r1 = {1'b0, a_i} + {1'b0, b_i} + {{BLOCK{1'b0}}, 1'b1};

  assign {c_o, s_o} = c_i ? r1 : r0;

  // carry into the slice MSB, recovered from the MSB sum bit
  assign mc_o = s_o[BLOCK-1] ^ a_i[BLOCK-1] ^ b_i[BLOCK-1];

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready flow
// control, signed overflow flag and a sticky overflow latch.
module csa_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH  = CSA_WIDTH,
  parameter int BLOCK  = CSA_BLOCK,
  parameter int STAGES = CSA_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = NBLK / STAGES;
  localparam int SW   = BPS * BLOCK;

  if (!csa_params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
    $fatal(1, "csa_pipe: illegal WIDTH/BLOCK/STAGES");
  end

  logic [STAGES-1:0][WIDTH-1:0] ai_w, bi_w, si_w, so_w;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0][BPS-1:0]   mcb_w;
  logic [STAGES-1:0]            ci_w, co_w, vi_w;
  logic [STAGES-1:0]            v_q, c_q;
  logic [STAGES:0]              rdy;
  logic                         ov_q;
  logic                         sticky_q;
  logic                         unused_w;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0] & ~rst;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * SW;

    logic [BPS:0]       cc;
    logic [SW-1:0]      bs;
    logic [WIDTH-1:0]   so;

    assign rdy[s] = ~v_q[s] | rdy[s+1];

    if (s == 0) begin : g_in
      assign vi_w[s] = in_valid & in_ready;
      assign ai_w[s] = a;
      assign bi_w[s] = sub ? ~b : b;
      assign ci_w[s] = cin ^ sub;
      assign si_w[s] = '0;
    end else begin : g_mid
      assign vi_w[s] = v_q[s-1];
      assign ai_w[s] = a_q[s-1];
      assign bi_w[s] = b_q[s-1];
      assign ci_w[s] = c_q[s-1];
      assign si_w[s] = s_q[s-1];
    end

    assign cc[0] = ci_w[s];

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      csa_block #(.BLOCK(BLOCK)) u_blk (
        .a_i  (ai_w[s][LO + j*BLOCK +: BLOCK]),
        .b_i  (bi_w[s][LO + j*BLOCK +: BLOCK]),
        .c_i  (cc[j]),
        .s_o  (bs[j*BLOCK +: BLOCK]),
        .c_o  (cc[j+1]),
        .mc_o (mcb_w[s][j])
      );
    end

    always_comb begin
      so = si_w[s];
      so[LO +: SW] = bs;
    end

    assign so_w[s] = so;
    assign co_w[s] = cc[BPS];
  end

  // a stage loads whenever it is empty or its content moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      c_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) begin
          v_q[s] <= vi_w[s];
          if (vi_w[s]) begin
            a_q[s] <= ai_w[s];
            b_q[s] <= bi_w[s];
            s_q[s] <= so_w[s];
            c_q[s] <= co_w[s];
          end
        end
      end
      if (rdy[STAGES-1] && vi_w[STAGES-1]) begin
        ov_q <= mcb_w[STAGES-1][BPS-1] ^ co_w[STAGES-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (out_valid && out_ready && ov_q) begin
      sticky_q <= 1'b1;
    end else if (clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign out_valid  = v_q[STAGES-1];
  assign sum        = s_q[STAGES-1];
  assign cout       = c_q[STAGES-1];
  assign overflow   = ov_q;
  assign ovf_sticky = sticky_q;

  assign unused_w = ^{a_q, b_q, ai_w, bi_w, mcb_w};

endmodule

// File: tb/tb_csa_pipe.sv
// Directed and randomised checks of csa_pipe: a 32-bit/2-stage
// instance for directed vectors and a 16-bit/4-stage one for a stream.
module tb_csa_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, overflow, ovf_sticky, clr;

  logic        r_in_valid, r_in_ready;
  logic [15:0] r_a, r_b;
  logic        r_cin, r_sub;
  logic        r_out_valid, r_out_ready;
  logic [15:0] r_sum;
  logic        r_cout, r_overflow, r_ovf_sticky, r_clr;

  int n_chk  = 0;
  int n_pass = 0;

  logic [17:0] q[$];

  always #5 clk = ~clk;

  csa_pipe u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky),
    .clr        (clr)
  );

  csa_pipe #(.WIDTH(16), .BLOCK(4), .STAGES(4)) u_r (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (r_in_valid),
    .in_ready   (r_in_ready),
    .a          (r_a),
    .b          (r_b),
    .cin        (r_cin),
    .sub        (r_sub),
    .out_valid  (r_out_valid),
    .out_ready  (r_out_ready),
    .sum        (r_sum),
    .cout       (r_cout),
    .overflow   (r_overflow),
    .ovf_sticky (r_ovf_sticky),
    .clr        (r_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // {overflow, cout, sum} by plain integer arithmetic
  function automatic logic [17:0] model16(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c,
                                          input logic s);
    logic [15:0] yy;
    logic [16:0] f;
    logic        ov;
    yy = s ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + {16'd0, c ^ s};
    ov = (x[15] == yy[15]) && (f[15] != x[15]);
    return {ov, f[16], f[15:0]};
  endfunction

  // one isolated beat, checked STAGES=2 cycles after acceptance
  task automatic one(input string tag, input logic [31:0] ta,
                     input logic [31:0] tb, input logic tc,
                     input logic ts, input logic [31:0] es,
                     input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    #1 chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".sum"}, 64'(sum), 64'(es));
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
    chk({tag, ".ovf"}, 64'(overflow), 64'(eo));
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic rnd_pop();
    if (r_out_valid && r_out_ready) begin
      if (q.size() == 0) chk("rnd.spurious", 64'd1, 64'd0);
      else chk("rnd.beat", 64'({r_overflow, r_cout, r_sum}),
               64'(q.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    sub = 1'b0; out_ready = 1'b1; clr = 1'b0;
    r_in_valid = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0;
    r_sub = 1'b0; r_out_ready = 1'b1; r_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.r_in_ready", 64'(r_in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst.rel_in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sum", 64'(sum), 64'd0);
    chk("rst.cout_ovf", 64'({cout, overflow}), 64'd0);
    chk("rst.sticky", 64'(ovf_sticky), 64'd0);

    one("max_pos", 32'h7fffffff, 32'h7fffffff, 1'b0, 1'b0,
        32'hfffffffe, 1'b0, 1'b1);
    @(negedge clk);
    chk("max_pos.drained", 64'(out_valid), 64'd0);
    chk("max_pos.sticky", 64'(ovf_sticky), 64'd1);
    do_clr();
    chk("clr1.sticky", 64'(ovf_sticky), 64'd0);

    one("neg_ovf", 32'h80000000, 32'hffffffff, 1'b0, 1'b0,
        32'h7fffffff, 1'b1, 1'b1);
    @(negedge clk);
    chk("neg_ovf.sticky", 64'(ovf_sticky), 64'd1);
    do_clr();
    chk("clr2.sticky", 64'(ovf_sticky), 64'd0);

    one("sub_borrow", 32'h00000005, 32'h00000007, 1'b0, 1'b1,
        32'hfffffffe, 1'b0, 1'b0);
    one("add_cin", 32'h12345678, 32'h12345670, 1'b1, 1'b0,
        32'h2468ace9, 1'b0, 1'b0);
    one("sub_bin", 32'h00000010, 32'h00000003, 1'b1, 1'b1,
        32'h0000000c, 1'b1, 1'b0);
    @(negedge clk);
    chk("no_ovf.sticky", 64'(ovf_sticky), 64'd0);

    // overflow transfer coinciding with clr: set wins
    one("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1,
        32'h7fffffff, 1'b1, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("set_wins.sticky", 64'(ovf_sticky), 64'd1);
    do_clr();
    chk("clr3.sticky", 64'(ovf_sticky), 64'd0);

    // backpressure: three beats offered back-to-back with out_ready=0
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    a = 32'd1; b = 32'd1; cin = 1'b0; sub = 1'b0;
    #1 chk("bp.rdy1", 64'(in_ready), 64'd1);
    @(negedge clk);
    a = 32'd2; b = 32'd3;
    #1 chk("bp.rdy2", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp.valid", 64'(out_valid), 64'd1);
    chk("bp.sum_a", 64'(sum), 64'd2);
    a = 32'hffffffff; b = 32'd1;
    #1 chk("bp.full", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp.hold_sum", 64'(sum), 64'd2);
    chk("bp.hold_flags", 64'({out_valid, cout, overflow}), 64'b100);
    chk("bp.hold_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp.hold_sum2", 64'(sum), 64'd2);
    out_ready = 1'b1;
    #1 chk("bp.release_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.second", 64'({out_valid, cout, sum}), {31'd0, 1'b1, 1'b0, 32'd5});
    @(negedge clk);
    chk("bp.third", 64'({out_valid, cout, sum}), {31'd0, 1'b1, 1'b1, 32'd0});
    @(negedge clk);
    chk("bp.empty", 64'(out_valid), 64'd0);

    // reset with two overflowing beats in flight
    @(negedge clk);
    a = 32'h7fffffff; b = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid.inflight", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid.valid", 64'(out_valid), 64'd0);
    chk("mid.sticky", 64'(ovf_sticky), 64'd0);
    chk("mid.rdy_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid.no_stale", 64'(out_valid), 64'd0);
    end
    chk("mid.sticky_after", 64'(ovf_sticky), 64'd0);

    // random stream on the 16-bit, 4-stage instance
    for (int i = 0; i < 16000; i++) begin
      @(negedge clk);
      r_a = 16'($urandom);
      r_b = 16'($urandom);
      r_cin = 1'($urandom_range(0, 1));
      r_sub = 1'($urandom_range(0, 1));
      r_in_valid = ($urandom_range(0, 9) != 0);
      r_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      rnd_pop();
      if (r_in_valid && r_in_ready)
        q.push_back(model16(r_a, r_b, r_cin, r_sub));
    end
    @(negedge clk);
    r_in_valid = 1'b0;
    r_out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      #1 rnd_pop();
      @(negedge clk);
    end
    chk("rnd.drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
